// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the serial subtractor.
package serial_sub_pkg;

    localparam int SUB_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

endpackage

// File: rtl/serial_subtractor_8bit_if.sv
// Request/result bundle between a requester and the serial subtractor.
// Optional macro SERIAL_SUB_OVF_EN adds the signed-overflow flag ovf.
interface serial_subtractor_8bit_if
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;
    logic             done;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, bin, input diff, bout, busy, done, ovf);
    modport slave  (input start, a, b, bin, output diff, bout, busy, done, ovf);
`else
    modport master (output start, a, b, bin, input diff, bout, busy, done);
    modport slave  (input start, a, b, bin, output diff, bout, busy, done);
`endif
endinterface

// File: rtl/serial_subtractor_8bit_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock.
// Optional macro SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
//
// state | meaning
// IDLE  | waiting for start; operands captured when start is seen
// SHIFT | one bit per cycle through the shared full subtractor (busy=1)
// DONE  | one-cycle done pulse, diff/bout valid
module serial_subtractor_8bit
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    serial_subtractor_8bit_if.slave bus
);
    localparam int             CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    sub_state_t       state, state_nx;
    logic [WIDTH-1:0] areg, breg, res, diff_q;
    logic [CW-1:0]    count;
    logic             brw, bout_q;
    logic             bit_d, bit_bout;
    logic             busy_c, done_c;

    full_subtractor u_fs (
        .a    (areg[0]),
        .b    (breg[0]),
        .bin  (brw),
        .d    (bit_d),
        .bout (bit_bout)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and status decode.
    always_comb begin
        state_nx = state;
        busy_c   = 1'b0;
        done_c   = 1'b0;
        case (state)
            IDLE:  if (bus.start) state_nx = SHIFT;
            SHIFT: begin
                busy_c = 1'b1;
                if (count == LAST) state_nx = DONE;
            end
            DONE: begin
                done_c   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, bit-serial shift, and result publish on the last bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            areg   <= '0;
            breg   <= '0;
            res    <= '0;
            brw    <= 1'b0;
            count  <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    areg  <= bus.a;
                    breg  <= bus.b;
                    brw   <= bus.bin;
                    count <= '0;
                end
                SHIFT: begin
                    areg  <= areg >> 1;
                    breg  <= breg >> 1;
                    brw   <= bit_bout;
                    res   <= {bit_d, res[WIDTH-1:1]};
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        diff_q <= {bit_d, res[WIDTH-1:1]};
                        bout_q <= bit_bout;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q;

    // On the last bit areg[0]/breg[0] hold the operand sign bits and bit_d is the result sign.
    always_ff @(posedge clk) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else if (state == SHIFT && count == LAST)
            ovf_q <= (areg[0] != breg[0]) & (bit_d != areg[0]);
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.busy = busy_c;
    assign bus.done = done_c;

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Directed-vector bench for serial_subtractor_8bit.
module tb_serial_subtractor_8bit;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;

    serial_subtractor_8bit_if #(.WIDTH(8)) bus ();

    serial_subtractor_8bit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // One full operation; called at a falling edge with the DUT in IDLE, returns likewise.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic biv,
                         input logic [7:0] ed, input logic eb, input logic eo, input string nm);
        int lat;
        int busy_n;
        bus.a = av; bus.b = bv; bus.bin = biv; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        busy_n = 0;
        while (bus.done !== 1'b1 && lat < 30) begin
            if (bus.busy === 1'b1) busy_n++;
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (lat !== 9) begin
            miscompares++;
            $display("FAIL %s latency: got %0d cycles, expected 9", nm, lat);
        end
        vectors++;
        if (busy_n !== 8) begin
            miscompares++;
            $display("FAIL %s busy cycles: got %0d, expected 8", nm, busy_n);
        end
        vectors++;
        if (bus.diff !== ed) begin
            miscompares++;
            $display("FAIL %s diff: got %h, expected %h", nm, bus.diff, ed);
        end
        vectors++;
        if (bus.bout !== eb) begin
            miscompares++;
            $display("FAIL %s bout: got %b, expected %b", nm, bus.bout, eb);
        end
`ifdef SERIAL_SUB_OVF_EN
        vectors++;
        if (bus.ovf !== eo) begin
            miscompares++;
            $display("FAIL %s ovf: got %b, expected %b", nm, bus.ovf, eo);
        end
`endif
        @(negedge clk);
        vectors++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s after-done: got done=%b busy=%b, expected 0 0", nm, bus.done, bus.busy);
        end
        vectors++;
        if (bus.diff !== ed) begin
            miscompares++;
            $display("FAIL %s diff hold: got %h, expected %h", nm, bus.diff, ed);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.a = 8'hFF; bus.b = 8'h01; bus.bin = 1'b0; bus.start = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset status: got busy=%b done=%b, expected 0 0", bus.busy, bus.done);
        end
        vectors++;
        if (bus.diff !== 8'h00 || bus.bout !== 1'b0) begin
            miscompares++;
            $display("FAIL reset result: got diff=%h bout=%b, expected 00 0", bus.diff, bus.bout);
        end
`ifdef SERIAL_SUB_OVF_EN
        vectors++;
        if (bus.ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset ovf: got %b, expected 0", bus.ovf);
        end
`endif
        bus.start = 1'b0;
        rst_n = 1'b1;
    endtask

    // Must directly follow test_reset: start is accepted on the first edge out of reset.
    task automatic test_basic;
        do_op(8'h0F, 8'h01, 1'b0, 8'h0E, 1'b0, 1'b0, "basic_0F_01");
    endtask

    task automatic test_wrap;
        do_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "wrap_00_01");
        do_op(8'hAA, 8'h55, 1'b1, 8'h54, 1'b0, 1'b1, "AA_55_b1");
        do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "FF_FF_b1");
        do_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "80_01");
        do_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, "7F_FF");
        do_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, "00_00_b1");
        do_op(8'h3C, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, "3C_3C");
    endtask

    task automatic test_ignore_start;
        int lat;
        int extra_done;
        int extra_busy;
        bus.a = 8'h50; bus.b = 8'h20; bus.bin = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 30) begin
            if (lat == 3) begin
                bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h02; bus.bin = 1'b1;
            end else if (lat == 4) begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (lat !== 9) begin
            miscompares++;
            $display("FAIL ignore_start latency: got %0d, expected 9", lat);
        end
        vectors++;
        if (bus.diff !== 8'h30 || bus.bout !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_start result: got diff=%h bout=%b, expected 30 0", bus.diff, bus.bout);
        end
        extra_done = 0;
        extra_busy = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done === 1'b1) extra_done++;
            if (bus.busy === 1'b1) extra_busy++;
        end
        vectors++;
        if (extra_done !== 0 || extra_busy !== 0) begin
            miscompares++;
            $display("FAIL ignore_start queued: got done=%0d busy=%0d cycles, expected 0 0", extra_done, extra_busy);
        end
    endtask

    task automatic test_reset_abort;
        int lat;
        int extra_done;
        int extra_busy;
        bus.a = 8'h0F; bus.b = 8'h01; bus.bin = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (lat < 4) begin
            @(negedge clk);
            lat++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort status: got busy=%b done=%b, expected 0 0", bus.busy, bus.done);
        end
        vectors++;
        if (bus.diff !== 8'h00 || bus.bout !== 1'b0) begin
            miscompares++;
            $display("FAIL abort result: got diff=%h bout=%b, expected 00 0", bus.diff, bus.bout);
        end
        rst_n = 1'b1;
        extra_done = 0;
        extra_busy = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done === 1'b1) extra_done++;
            if (bus.busy === 1'b1) extra_busy++;
        end
        vectors++;
        if (extra_done !== 0 || extra_busy !== 0) begin
            miscompares++;
            $display("FAIL abort leftover: got done=%0d busy=%0d cycles, expected 0 0", extra_done, extra_busy);
        end
        do_op(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, "after_abort");
    endtask

    task automatic test_back_to_back;
        logic [7:0] oa [3];
        logic [7:0] ob [3];
        logic [7:0] od [3];
        logic       obi[3];
        logic       obo[3];
        int k;
        int last_i;
        int gap;
        oa[0] = 8'h12; ob[0] = 8'h34; obi[0] = 1'b0; od[0] = 8'hDE; obo[0] = 1'b1;
        oa[1] = 8'hC8; ob[1] = 8'h64; obi[1] = 1'b1; od[1] = 8'h63; obo[1] = 1'b0;
        oa[2] = 8'h01; ob[2] = 8'h80; obi[2] = 1'b0; od[2] = 8'h81; obo[2] = 1'b1;
        k = 0;
        last_i = 0;
        bus.a = oa[0]; bus.b = ob[0]; bus.bin = obi[0]; bus.start = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 30) bus.start = 1'b0;
            if (i == 10 || i == 20) begin
                vectors++;
                if (bus.busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b idle gap at %0d: got busy=%b, expected 0", i, bus.busy);
                end
            end
            if (i == 11 || i == 21) begin
                vectors++;
                if (bus.busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b restart at %0d: got busy=%b, expected 1", i, bus.busy);
                end
            end
            if (bus.done === 1'b1 && k < 3) begin
                gap = i - last_i;
                vectors++;
                if (gap !== ((k == 0) ? 9 : 10)) begin
                    miscompares++;
                    $display("FAIL b2b spacing op%0d: got %0d, expected %0d", k, gap, (k == 0) ? 9 : 10);
                end
                vectors++;
                if (bus.diff !== od[k] || bus.bout !== obo[k]) begin
                    miscompares++;
                    $display("FAIL b2b result op%0d: got diff=%h bout=%b, expected %h %b",
                             k, bus.diff, bus.bout, od[k], obo[k]);
                end
                last_i = i;
                k++;
                if (k < 3) begin
                    bus.a = oa[k]; bus.b = ob[k]; bus.bin = obi[k];
                end
            end
        end
        vectors++;
        if (k !== 3) begin
            miscompares++;
            $display("FAIL b2b done count: got %0d, expected 3", k);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        bus.bin   = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_wrap;
        test_ignore_start;
        test_reset_abort;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_subtractor_8bit.md
SERIAL_SUBTRACTOR_8BIT -- requirements
Module: serial_subtractor_8bit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result bit width (counter sized $clog2(WIDTH)+1).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin a subtraction, sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  minuend, captured on accepted start.
REQ-006 SHALL have port b  input  WIDTH  subtrahend, captured on accepted start.
REQ-007 SHALL have port bin  input  1  borrow-in, captured on accepted start.
REQ-008 SHALL have port diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-009 SHALL have port bout  output  1  borrow-out, 1 when unsigned a < b + bin.
REQ-010 SHALL have port busy  output  1  high while in SHIFT.
REQ-011 SHALL have port done  output  1  single-cycle pulse, diff/bout valid.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 IDLE: start=1 -> capture a, b, bin into shift registers, clear count, go SHIFT next cycle.
REQ-014 SHIFT: each cycle process one bit LSB first: d = a0^b0^brw, brw' = (~a0&b0)|(~(a0^b0)&brw); shift d into result MSB; count++.
REQ-015 SHIFT -> DONE after exactly WIDTH cycles; DONE -> IDLE unconditionally next cycle.
REQ-016 Latency: done asserts in the cycle WIDTH+1 clocks after the edge sampling start (9 for WIDTH=8).
REQ-017 done SHALL be high only in DONE, exactly one cycle per accepted start.
REQ-018 diff/bout SHALL update only at SHIFT->DONE transition and hold until next completion or reset.
REQ-019 start in SHIFT or DONE SHALL be ignored (no queuing); inputs a/b/bin changing during SHIFT SHALL not affect result.
REQ-020 start held high continuously SHALL yield back-to-back operations with one IDLE cycle between done and next busy.
REQ-021 Wrap-around: underflow result SHALL be two's-complement modulo 2^WIDTH with bout=1.

Reset
REQ-022 rst_n=0 at clock edge SHALL force IDLE, count=0, diff=0, bout=0, busy=0, done=0 (and ovf=0 if present).
REQ-023 Reset during SHIFT SHALL abort the operation; no done pulse for the aborted operation.
REQ-024 First start SHALL be accepted on the first edge with rst_n=1.

Configuration
REQ-025 Macro SERIAL_SUB_OVF_EN defined: extra output ovf (1 bit), signed overflow = (a[MSB]!=b[MSB]) & (diff[MSB]!=a[MSB]), updated with diff.
REQ-026 Macro undefined: ovf port and its logic absent; all other behaviour identical.

Structure
REQ-027 Shared package serial_sub_pkg SHALL hold state enum type (IDLE/SHIFT/DONE) and default WIDTH constant.
REQ-028 Per-bit logic SHALL be a sub-module full_subtractor (a, b, bin -> d, bout), one instance, reused each cycle.

Verification
REQ-029 a=0x0F, b=0x01, bin=0, start -> done after 9 cycles, diff=0x0E, bout=0.
REQ-030 a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; a=0xAA, b=0x55, bin=1 -> diff=0x54, bout=0.
REQ-031 a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1; with SERIAL_SUB_OVF_EN, a=0x80, b=0x01, bin=0 -> diff=0x7F, ovf=1.
REQ-032 start pulsed again 3 cycles into SHIFT with different operands -> ignored, single done with first result.
REQ-033 rst_n=0 at SHIFT cycle 4 -> next cycle busy=0, diff=0, bout=0, no done; new start afterwards completes correctly.
REQ-034 start held high for 30 cycles -> done pulses every 10 cycles, each with correct result.
